// File: rtl/lpc_record_if.sv
// ---------------------------------------------------------------------------
// lpc_record_if
// Bundles the decoded-cycle input strobe and the host-facing byte stream of
// the LPC record scheduler.
//   in_valid      one-cycle strobe from the cycle decoder
//   in_ct_dir     cycle type / direction
//   in_addr       cycle address
//   in_data       cycle data
//   in_data_size  data size in bytes
//   out_byte      frame byte towards the host transport
//   out_valid     out_byte valid
//   out_ready     host transport accepts the byte
// Modports:
//   slave  - the scheduler (consumes records, produces bytes)
//   master - decoder + byte sink side (produces records, consumes bytes)
// ---------------------------------------------------------------------------
interface lpc_record_if;
    logic        in_valid;
    logic [3:0]  in_ct_dir;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [2:0]  in_data_size;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;

    modport slave (
        input  in_valid,
        input  in_ct_dir,
        input  in_addr,
        input  in_data,
        input  in_data_size,
        input  out_ready,
        output out_byte,
        output out_valid
    );

    modport master (
        output in_valid,
        output in_ct_dir,
        output in_addr,
        output in_data,
        output in_data_size,
        output out_ready,
        input  out_byte,
        input  out_valid
    );
endinterface

// File: rtl/lpc_record_scheduler.sv
// ---------------------------------------------------------------------------
// lpc_record_scheduler
// Buffers decoded LPC cycles in a circular record FIFO and serialises each
// record as a fixed byte frame (MSB first) over a valid/ready byte stream.
// Records arriving while the FIFO is full are dropped; the next stored record
// carries an overflow flag (bit 3 of its first byte) so the host sees the gap.
//
// Frame: B0 = {ct_dir, ovf, data_size}, B1..B4 = addr, B5..B8 = data.
// Optional build macro LPC_SYNC_BYTE_EN: prefix every frame with a 0xA5
// marker byte (10-byte frames).
//
// Ports:
//   lpc_clock   LPC clock, rising edge
//   lpc_reset   asynchronous reset, active high
//   enable      capture enable; when low, in_valid strobes are ignored
//   bus         lpc_record_if.slave: record input + byte output handshake
//   fifo_level  records stored (excluding the one being serialised)
//   drop_count  records dropped since reset, saturating
//   busy        FIFO non-empty or frame in flight
// ---------------------------------------------------------------------------
module lpc_record_scheduler #(
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned DROP_W     = 16
) (
    input  logic                  lpc_clock,
    input  logic                  lpc_reset,
    input  logic                  enable,
    lpc_record_if.slave           bus,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic [DROP_W-1:0]     drop_count,
    output logic                  busy
);

    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W    = DEPTH_LOG2;
    localparam int unsigned LVL_W    = DEPTH_LOG2 + 1;
    localparam int unsigned REC_W    = 72;
`ifdef LPC_SYNC_BYTE_EN
    localparam int unsigned FRAME_BYTES = 10;
`else
    localparam int unsigned FRAME_BYTES = 9;
`endif
    localparam int unsigned SR_W     = FRAME_BYTES * 8;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned LAST_IDX = FRAME_BYTES - 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_e;

    // Record storage (no reset needed: only read when the level says valid)
    logic [REC_W-1:0]  mem_q [DEPTH];

    state_e            state_q,     state_d;
    logic [IDX_W-1:0]  idx_q,       idx_d;
    logic [SR_W-1:0]   sr_q,        sr_d;
    logic              out_valid_q, out_valid_d;
    logic [PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,    rd_ptr_d;
    logic [LVL_W-1:0]  level_q,     level_d;
    logic [DROP_W-1:0] drop_q,      drop_d;
    logic              ovf_q,       ovf_d;
    logic              busy_q,      busy_d;

    logic              hs;
    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic              wr_req;
    logic              accept;
    logic [REC_W-1:0]  head_rec;
    logic [REC_W-1:0]  wr_rec;

    assign head_rec = mem_q[rd_ptr_q];
    assign wr_rec   = {bus.in_ct_dir, ovf_q, bus.in_data_size,
                       bus.in_addr, bus.in_data};

    // Next-state: frame FSM, FIFO pointers/level, drop accounting
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sr_d        = sr_q;
        out_valid_d = out_valid_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        drop_d      = drop_q;
        ovf_d       = ovf_q;
        pop         = 1'b0;

        hs         = out_valid_q && bus.out_ready;
        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == LVL_W'(DEPTH));

        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                end
            end
            S_SEND: begin
                if (hs) begin
                    if (idx_q == IDX_W'(LAST_IDX)) begin
                        // Last byte accepted: reload back-to-back or go idle
                        if (!fifo_empty) begin
                            pop = 1'b1;
                        end else begin
                            state_d     = S_IDLE;
                            out_valid_d = 1'b0;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        sr_d  = {sr_q[SR_W-9:0], 8'h00};
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (pop) begin
`ifdef LPC_SYNC_BYTE_EN
            sr_d = {8'hA5, head_rec};
`else
            sr_d = head_rec;
`endif
            idx_d       = '0;
            state_d     = S_SEND;
            out_valid_d = 1'b1;
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
        end

        // A pop in the same cycle frees a slot, so a full FIFO still accepts
        wr_req = bus.in_valid && enable;
        accept = wr_req && (!fifo_full || pop);

        if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            ovf_d    = 1'b0;
        end else if (wr_req) begin
            ovf_d = 1'b1;
            if (!(&drop_q)) begin
                drop_d = drop_q + DROP_W'(1);
            end
        end

        if (accept && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !accept) begin
            level_d = level_q - LVL_W'(1);
        end

        busy_d = (level_d != '0) || (state_d == S_SEND);
    end

    // State registers
    always_ff @(posedge lpc_clock or posedge lpc_reset) begin
        if (lpc_reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            sr_q        <= '0;
            out_valid_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            drop_q      <= '0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sr_q        <= sr_d;
            out_valid_q <= out_valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            drop_q      <= drop_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
        end
    end

    // Record storage write port
    always_ff @(posedge lpc_clock) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= wr_rec;
        end
    end

    // Current frame byte is always the top of the shift register
    assign bus.out_byte  = sr_q[SR_W-1 -: 8];
    assign bus.out_valid = out_valid_q;
    assign fifo_level    = level_q;
    assign drop_count    = drop_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_lpc_record_scheduler.sv
// ---------------------------------------------------------------------------
// tb_lpc_record_scheduler
// Randomised bench for lpc_record_scheduler. A queue-based reference model
// decides which records are stored or dropped and pushes every expected frame
// byte into a scoreboard; a forked monitor pops and compares each byte the DUT
// hands over, and checks byte stability under backpressure.
// ---------------------------------------------------------------------------
module tb_lpc_record_scheduler;

    localparam int unsigned DEPTH_LOG2 = 3;
    localparam int unsigned DROP_W     = 16;
    localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
`ifdef LPC_SYNC_BYTE_EN
    localparam int FRAME = 10;
`else
    localparam int FRAME = 9;
`endif

    logic                  clk;
    logic                  rst;
    logic                  enable;
    logic [DEPTH_LOG2:0]   fifo_level;
    logic [DROP_W-1:0]     drop_count;
    logic                  busy;

    lpc_record_if vif ();

    lpc_record_scheduler #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DROP_W     (DROP_W)
    ) dut (
        .lpc_clock  (clk),
        .lpc_reset  (rst),
        .enable     (enable),
        .bus        (vif.slave),
        .fifo_level (fifo_level),
        .drop_count (drop_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Reference model state
    logic [71:0] stored_q [$];
    logic [7:0]  exp_q [$];
    int          remaining;
    bit          ovf_pend;
    int          drops;
    bit          in_reset;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_frame(input logic [71:0] r);
`ifdef LPC_SYNC_BYTE_EN
        exp_q.push_back(8'hA5);
`endif
        for (int i = 8; i >= 0; i--) begin
            logic [7:0] b;
            b = r[i*8 +: 8];
            exp_q.push_back(b);
        end
    endtask

    // Advance the model across the coming rising edge using the driven inputs
    task automatic model_step();
        bit hs;
        hs = (remaining > 0) && vif.out_ready;
        if (hs) remaining--;
        if (remaining == 0 && stored_q.size() > 0) begin
            void'(stored_q.pop_front());
            remaining = FRAME;
        end
        if (vif.in_valid && enable) begin
            if (stored_q.size() < DEPTH) begin
                logic [71:0] r;
                r = {vif.in_ct_dir, ovf_pend, vif.in_data_size, vif.in_addr, vif.in_data};
                stored_q.push_back(r);
                push_frame(r);
                ovf_pend = 1'b0;
            end else begin
                ovf_pend = 1'b1;
                if (drops < (1 << DROP_W) - 1) drops++;
            end
        end
    endtask

    task automatic check_status();
        check("out_valid", longint'(vif.out_valid), longint'(remaining > 0));
        check("fifo_level", longint'(fifo_level), longint'(stored_q.size()));
        check("drop_count", longint'(drop_count), longint'(drops));
        check("busy", longint'(busy), longint'((remaining > 0) || (stored_q.size() > 0)));
    endtask

    task automatic step(input bit v, input bit en, input bit rdy,
                        input logic [3:0] ct, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        #1;
        check_status();
        vif.in_valid     = v;
        enable           = en;
        vif.out_ready    = rdy;
        vif.in_ct_dir    = ct;
        vif.in_data_size = sz;
        vif.in_addr      = a;
        vif.in_data      = d;
        model_step();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, rdy, 4'h0, 3'd0, 32'h0, 32'h0);
    endtask

    task automatic rand_push(input bit rdy);
        step(1'b1, 1'b1, rdy, 4'($urandom), 3'($urandom), $urandom, $urandom);
    endtask

    // Drain everything with a bounded cycle budget
    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || remaining > 0 || stored_q.size() > 0) && n < 2000) begin
            step(1'b0, 1'b1, ($urandom_range(0, 3) != 0), 4'h0, 3'd0, 32'h0, 32'h0);
            n++;
        end
        check({name, "_drain_timeout"}, longint'(n < 2000), 1);
        idle(2, 1'b1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #1;
        rst          = 1'b1;
        in_reset     = 1'b1;
        vif.in_valid = 1'b0;
        #1;
        check("rst_out_valid", longint'(vif.out_valid), 0);
        check("rst_out_byte", longint'(vif.out_byte), 0);
        check("rst_fifo_level", longint'(fifo_level), 0);
        check("rst_drop_count", longint'(drop_count), 0);
        check("rst_busy", longint'(busy), 0);
        stored_q.delete();
        exp_q.delete();
        remaining = 0;
        ovf_pend  = 1'b0;
        drops     = 0;
        repeat (2) @(negedge clk);
        #1;
        rst      = 1'b0;
        in_reset = 1'b0;
    endtask

    // Scoreboard monitor: compares every handshaken byte, checks hold on stall
    task automatic monitor();
        bit         prev_stall;
        logic [7:0] prev_byte;
        prev_stall = 1'b0;
        prev_byte  = 8'h00;
        forever begin
            @(negedge clk);
            #2;
            if (in_reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", longint'(vif.out_valid), 1);
                    check("hold_byte", longint'(vif.out_byte), longint'(prev_byte));
                end
                if (vif.out_valid && vif.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", longint'(vif.out_byte), -1);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        check("frame_byte", longint'(vif.out_byte), longint'(e));
                    end
                end
                prev_stall = vif.out_valid && !vif.out_ready;
                prev_byte  = vif.out_byte;
            end
        end
    endtask

    initial begin
        n_checks         = 0;
        n_errors         = 0;
        remaining        = 0;
        ovf_pend         = 1'b0;
        drops            = 0;
        rst              = 1'b1;
        in_reset         = 1'b1;
        enable           = 1'b1;
        vif.in_valid     = 1'b0;
        vif.in_ct_dir    = 4'h0;
        vif.in_addr      = 32'h0;
        vif.in_data      = 32'h0;
        vif.in_data_size = 3'd0;
        vif.out_ready    = 1'b1;

        fork
            monitor();
        join_none

        apply_reset();

        // Single IO read
        step(1'b1, 1'b1, 1'b1, 4'h0, 3'd1, 32'h0000_7FE5, 32'h0000_006C);
        drain("single");

        // Two back-to-back strobes, sink always ready
        step(1'b1, 1'b1, 1'b1, 4'h0, 3'd1, 32'h0000_7FE4, 32'h0000_006B);
        step(1'b1, 1'b1, 1'b1, 4'h0, 3'd1, 32'h0000_7FE5, 32'h0000_006C);
        idle(2 * FRAME + 3, 1'b1);
        drain("b2b");

        // One frame under random backpressure
        rand_push(1'b1);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'($urandom), 4'h0, 3'd0, 32'h0, 32'h0);
        drain("backpressure");

        // Overflow with stalled sink, then a partial drain and one more push
        for (int i = 0; i < 11; i++) rand_push(1'b0);
        idle(3, 1'b0);
        idle(FRAME, 1'b1);
        rand_push(1'b0);
        drain("overflow");

        // Capture disabled: strobes ignored
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 4'($urandom), 3'd4, $urandom, $urandom);
        idle(3, 1'b1);

        // Random mixed traffic
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 9) < 4), ($urandom_range(0, 15) != 0),
                 ($urandom_range(0, 9) < 6), 4'($urandom), 3'($urandom), $urandom, $urandom);
        end
        drain("random");

        // Reset mid-frame, then a fresh frame afterwards
        step(1'b1, 1'b1, 1'b1, 4'h2, 3'd4, 32'hDEAD_BEEF, 32'h1234_5678);
        idle(5, 1'b1);
        apply_reset();
        idle(2, 1'b1);
        step(1'b1, 1'b1, 1'b1, 4'h1, 3'd2, 32'h0000_0080, 32'h0000_55AA);
        drain("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lpc_record_scheduler.md
Name: lpc_record_scheduler

Overview:
- Sits between the LPC cycle decoder and the host-facing byte transport (UART TX / FTDI FIFO).
- Buffers decoded LPC cycles in a small record FIFO and serialises each record as a fixed byte frame over a valid/ready byte interface.
- Handles drops on overflow and flags them in-band, so the host sees every gap.

Parameters:
- DEPTH_LOG2, 3: record FIFO depth = 2**DEPTH_LOG2 records.
- DROP_W, 16: width of the saturating drop counter.

Ports:
- lpc_clock  in  1  LPC clock, rising-edge.
- lpc_reset  in  1  asynchronous reset, active-high.
- enable  in  1  capture enable; 0 ignores in_valid.
- in_valid  in  1  one-cycle strobe from decoder (its out_clock_enable).
- in_ct_dir  in  4  cycle type/direction.
- in_addr  in  32  cycle address.
- in_data  in  32  cycle data.
- in_data_size  in  3  data size in bytes.
- out_byte  out  8  frame byte.
- out_valid  out  1  out_byte valid.
- out_ready  in  1  sink accepts byte.
- fifo_level  out  DEPTH_LOG2+1  records stored.
- drop_count  out  DROP_W  records dropped since reset, saturating.
- busy  out  1  FIFO non-empty or frame in flight.

Behaviour:
- Reset (async, active-high): out_valid=0, out_byte=0, fifo_level=0, drop_count=0, busy=0, ovf_pending=0, FSM=IDLE. Reset mid-frame abandons the frame immediately; nothing resumes after release.
- Record format, 9 bytes, MSB first:
  - B0 = {ct_dir[3:0], ovf, data_size[2:0]}.
  - B1..B4 = addr[31:24..7:0].
  - B5..B8 = data[31:24..7:0].
- Write: at a rising edge with in_valid && enable:
  - If not full, or a pop occurs in the same cycle: store the record with ovf=ovf_pending, then clear ovf_pending.
  - Else: drop the record, set ovf_pending, drop_count+1 saturating at all-ones.
- in_valid while enable=0: ignored, not counted.
- FIFO: circular, pointers wrap modulo depth. fifo_level counts stored records, excluding the record in the shift register.
- FSM:
  - IDLE: if FIFO non-empty, pop head into 72-bit shift register, idx=0, go SEND.
  - SEND: out_valid=1, out_byte=byte[idx].
    - On out_valid&&out_ready with idx<8: idx+1.
    - On handshake with idx==8: if FIFO non-empty, pop and load in the same edge, idx=0, stay SEND (no idle cycle between frames); else go IDLE, out_valid=0.
- Handshake rules:
  - out_byte stable and out_valid held while out_ready=0.
  - out_valid never drops mid-frame except on reset.
- Latency: record written at edge k into an empty FIFO with FSM in IDLE → popped at edge k+1 → out_valid=1 with B0 after edge k+1.
- Full+pop+write in the same cycle: write accepted, level unchanged.
- Deasserting enable stops capture only. Stored and in-flight records drain normally.
- busy = (fifo_level!=0) || (FSM==SEND).

Optional Feature:
- LPC_SYNC_BYTE_EN defined:
  - Each frame is 10 bytes: a leading 0xA5 marker, then B0..B8.
  - idx runs 0..9; the back-to-back reload condition is idx==9.
- Not defined: 9-byte frames exactly as above, no marker logic.

Test Plan:
- Single IO read, ct_dir=0, size=1, addr=0x00007FE5, data=0x6C, out_ready=1 → bytes 01 00 00 7F E5 00 00 00 6C; out_valid first seen 2 edges after strobe; busy drops after last byte.
- Two back-to-back strobes (addr 0x7FE4/data 0x6B, then 0x7FE5/0x6C), out_ready=1 → 18 consecutive bytes, out_valid never low between frames.
- Backpressure: out_ready toggled 1,0,0,1 pseudo-randomly during a frame → out_byte constant whenever out_valid && !out_ready; 9 bytes delivered in order.
- Overflow, DEPTH_LOG2=3, out_ready=0:
  - Push 10 records → first held in shift register, fifo_level=8, drop_count=1.
  - 11th push → drop_count=2.
  - Then 12th push after one drain → its B0 bit3=1; all earlier records have bit3=0.
- enable=0 with 3 strobes → no write, drop_count unchanged. Reset asserted at byte 4 of a frame → out_valid=0 immediately, level 0; after release a new strobe yields a complete fresh frame.
- LPC_SYNC_BYTE_EN build, first scenario → A5 01 00 00 7F E5 00 00 00 6C.
